// File: rtl/dmem_access_unit.sv
// Data-memory access unit: turns core load/store requests into single-beat
// bus transactions, generating byte lanes, replicated store data and the
// sign/zero-extended load result.
module dmem_access_unit (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [3:0]  i_d_size,
  input  logic        i_d_unsigned,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_stall,
  output logic        o_access_err,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_gnt,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RSP,
    S_DONE
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic        size_ok;
  logic        acc_valid;
  logic        capture;
  logic        load_rdata;
  logic [7:0]  be_wide;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] rdata_shift;
  logic [31:0] rdata_ext;

  // Captured access attributes needed to extract the load result
  logic [1:0]  off_q;
  logic [3:0]  size_q;
  logic        unsigned_q;

  // Request decode: size legality, alignment and lane/data formatting
  always_comb begin
    size_ok = 1'b0;
    case (i_d_size)
      4'b0001: size_ok = 1'b1;
      4'b0011: size_ok = ~i_addr[0];
      4'b1111: size_ok = (i_addr[1:0] == 2'b00);
      default: size_ok = 1'b0;
    endcase
    acc_valid = (i_mem_read ^ i_mem_write) & size_ok;

    be_wide = {4'b0000, i_d_size} << i_addr[1:0];
    be_next = be_wide[3:0];

    case (i_d_size)
      4'b0001: wdata_next = {4{i_wdata[7:0]}};
      4'b0011: wdata_next = {2{i_wdata[15:0]}};
      default: wdata_next = i_wdata;
    endcase
  end

  // Load extraction from the raw bus word using the captured offset/size
  always_comb begin
    rdata_shift = i_bus_rdata >> {off_q, 3'b000};
    case (size_q)
      4'b0001: rdata_ext = unsigned_q ? {24'h000000, rdata_shift[7:0]}
                                      : {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      4'b0011: rdata_ext = unsigned_q ? {16'h0000, rdata_shift[15:0]}
                                      : {{16{rdata_shift[15]}}, rdata_shift[15:0]};
      default: rdata_ext = rdata_shift;
    endcase
  end

  // Next-state and control outputs; reset masks the combinational outputs
  // so nothing is asserted while the state register is being cleared
  always_comb begin
    state_d      = state_q;
    capture      = 1'b0;
    load_rdata   = 1'b0;
    o_stall      = 1'b0;
    o_access_err = 1'b0;
    o_bus_req    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (acc_valid) begin
          capture = 1'b1;
          o_stall = 1'b1;
          state_d = S_REQ;
        end else if (i_mem_read | i_mem_write) begin
          o_access_err = 1'b1;
        end
      end
      S_REQ: begin
        o_bus_req = 1'b1;
        o_stall   = 1'b1;
        if (i_bus_gnt) begin
          state_d = o_bus_we ? S_DONE : S_RSP;
        end
      end
      S_RSP: begin
        o_stall = 1'b1;
        if (i_bus_rvalid) begin
          load_rdata = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (i_reset) begin
      state_d      = S_IDLE;
      capture      = 1'b0;
      load_rdata   = 1'b0;
      o_stall      = 1'b0;
      o_access_err = 1'b0;
      o_bus_req    = 1'b0;
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Captured request: bus fields are held here so they stay stable until grant
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_bus_addr  <= '0;
      o_bus_be    <= '0;
      o_bus_wdata <= '0;
      o_bus_we    <= 1'b0;
      off_q       <= '0;
      size_q      <= '0;
      unsigned_q  <= 1'b0;
    end else if (capture) begin
      o_bus_addr  <= {i_addr[31:2], 2'b00};
      o_bus_be    <= be_next;
      o_bus_wdata <= wdata_next;
      o_bus_we    <= i_mem_write;
      off_q       <= i_addr[1:0];
      size_q      <= i_d_size;
      unsigned_q  <= i_d_unsigned;
    end
  end

  // Load result register, updated only when a read response is accepted
  always_ff @(posedge i_clk) begin
    if (i_reset)         o_rdata <= '0;
    else if (load_rdata) o_rdata <= rdata_ext;
  end

endmodule

// File: doc/dmem_access_unit.md
DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset.
REQ-002 i_clk  input  1  core clock; all state updates on rising edge.
REQ-003 i_reset  input  1  synchronous active-high reset.
REQ-004 i_mem_read  input  1  core load request, held while o_stall=1.
REQ-005 i_mem_write  input  1  core store request, held while o_stall=1.
REQ-006 i_d_size  input  4  access byte mask: 0001 byte, 0011 half, 1111 word.
REQ-007 i_d_unsigned  input  1  1 = zero-extend load, 0 = sign-extend.
REQ-008 i_addr  input  32  byte address from the ALU.
REQ-009 i_wdata  input  32  store data, LSB-aligned (rs2).
REQ-010 o_rdata  output  32  extended load result, registered.
REQ-011 o_stall  output  1  freeze core pipeline while the access is in flight.
REQ-012 o_access_err  output  1  one-cycle pulse for a rejected access.
REQ-013 o_bus_req  output  1  bus request valid.
REQ-014 o_bus_we  output  1  1 = write, 0 = read.
REQ-015 o_bus_addr  output  32  word-aligned address ({i_addr[31:2],2'b00}).
REQ-016 o_bus_be  output  4  lane byte enables.
REQ-017 o_bus_wdata  output  32  lane-replicated store data.
REQ-018 i_bus_gnt  input  1  bus accepted the request this cycle.
REQ-019 i_bus_rvalid  input  1  read data valid.
REQ-020 i_bus_rdata  input  32  raw read word.

Function
REQ-021 SHALL implement the states IDLE, REQ, RSP and DONE.
REQ-022 IDLE, valid access (exactly one of read/write, legal size, aligned): SHALL capture addr/size/unsigned/we/wdata, assert o_stall combinationally that cycle, and go to REQ.
REQ-023 Legal and aligned means: size 0001 at any offset; 0011 with addr[0]=0; 1111 with addr[1:0]=00.
REQ-024 IDLE, access with illegal size, misalignment, or read&write both set: SHALL pulse o_access_err for one cycle, issue no bus request, keep o_stall=0, and stay in IDLE.
REQ-025 REQ: o_bus_req=1; bus outputs driven from the captured registers and SHALL remain stable until i_bus_gnt; o_stall=1.
REQ-026 REQ with gnt, write: go to DONE.
REQ-027 REQ with gnt, read: go to RSP.
REQ-028 RSP: o_bus_req=0 and o_stall=1; i_bus_rvalid SHALL be sampled only in RSP (a rvalid during REQ is ignored); on rvalid, load o_rdata and go to DONE.
REQ-029 DONE: o_stall=0 for exactly one cycle so the core retires the instruction; next state IDLE; minimum load latency 3 cycles after the request appears with gnt in the first REQ cycle.
REQ-030 o_bus_be SHALL equal captured size shifted left by addr[1:0], truncated to 4 bits.
REQ-031 o_bus_wdata SHALL be {4{wdata[7:0]}} for byte, {2{wdata[15:0]}} for half, and wdata for word.
REQ-032 Load extract SHALL take rdata>>(8*addr[1:0]), then for byte/half keep the low 8/16 bits and extend with zeros if unsigned, else with the MSB; word passes through.
REQ-033 o_rdata SHALL hold its value until the next load completes; stores do not change it.
REQ-034 Back-to-back accesses SHALL incur one DONE bubble; there is no request overlap.

Reset
REQ-035 On i_reset: state=IDLE; o_rdata=0; o_stall, o_access_err, o_bus_req, o_bus_we, o_bus_be and o_bus_wdata=0; o_bus_addr=0.
REQ-036 Reset mid-operation (REQ/RSP) SHALL drop o_bus_req the next cycle; any later rvalid SHALL be ignored in IDLE.

Verification
REQ-037 SB: addr=0x1002, wdata=0x000000AB, gnt on 1st REQ cycle -> be=0100, wdata=0xABABABAB, bus_addr=0x1000, we=1, o_stall high 2 cycles then DONE.
REQ-038 LH signed: addr=0x2002, rdata=0x8001_7FFF, rvalid 2 cycles after gnt -> o_rdata=0xFFFF8001; LHU with the same stimulus -> 0x00008001.
REQ-039 LW addr=0x3001 -> o_access_err pulse, no o_bus_req, o_stall=0; size=0111 -> same response.
REQ-040 Gnt withheld 5 cycles with a store -> o_bus_req, addr, be and wdata stable all 5 cycles, o_stall=1 throughout, DONE after gnt.
REQ-041 Reset asserted in RSP, then rvalid with 0xDEADBEEF -> o_rdata stays 0, state IDLE, o_stall=0.
REQ-042 LB at addr offset 3, rdata=0x7F000000 followed immediately by SW -> o_rdata=0x0000007F, one DONE bubble, then store be=1111.
